// File: rtl/alarm_clock_multi.sv
// Alarm clock with seconds/minutes/hours/day-of-week timekeeping and
// NUM_ALARMS independent alarms, each with ring, snooze and auto-off.
// One Pulse edge per second; all state updates on the rising edge.
module alarm_clock_multi #(
    parameter int NUM_ALARMS   = 2,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_SEC = 600,
    localparam int SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  Pulse,
    input  logic                  Reset,
    input  logic                  Timeset,
    input  logic                  Alarmset,
    input  logic                  Minadv,
    input  logic                  Hrsadv,
    input  logic                  Dayadv,
    input  logic [SEL_W-1:0]      Alarmsel,
    input  logic [NUM_ALARMS-1:0] Alarmon,
    input  logic                  Snooze,
    input  logic                  Mode12,
    output logic [6:0]            Sec,
    output logic [6:0]            DispMin,
    output logic [6:0]            DispHrs,
    output logic [2:0]            Day,
    output logic                  PM,
    output logic [NUM_ALARMS-1:0] Active,
    output logic                  Buzz
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_e;

    // Snooze timer counts down to 1; ring timer counts up to RING_LAST.
    localparam logic [11:0] SNOOZE_CYC = 12'(SNOOZE_MIN * 60);
    localparam logic [11:0] RING_LAST  = 12'(RING_MAX_SEC - 1);

    logic [5:0]      sec_r;
    logic [5:0]      min_r;
    logic [4:0]      hrs_r;
    logic [2:0]      day_r;
    logic [5:0]      amin_r   [NUM_ALARMS];
    logic [4:0]      ahrs_r   [NUM_ALARMS];
    alarm_state_e    state_r  [NUM_ALARMS];
    logic [11:0]     timer_r  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] active_r;

    logic                  run_s;
    logic                  aset_s;
    logic [NUM_ALARMS-1:0] sel_hit_s;
    logic [5:0]            disp_min_s;
    logic [4:0]            disp_hrs24_s;
    logic [4:0]            disp_hrs_s;

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [2:0] inc_mod7(input logic [2:0] v);
        return (v == 3'd6) ? 3'd0 : v + 3'd1;
    endfunction

    assign run_s  = !Timeset && !Alarmset;
    assign aset_s = Alarmset && !Timeset;

    // One-hot decode of the alarm selector; out-of-range selects nothing.
    always_comb begin
        sel_hit_s = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            sel_hit_s[i] = (Alarmsel == SEL_W'(i));
        end
    end

    // Time of day: free-running with carries, button edits without carry, frozen during alarm set.
    always_ff @(posedge Pulse) begin
        if (Reset) begin
            sec_r <= 6'd0;
            min_r <= 6'd0;
            hrs_r <= 5'd0;
            day_r <= 3'd0;
        end else if (Timeset) begin
            if (Minadv) min_r <= inc_mod60(min_r);
            if (Hrsadv) hrs_r <= inc_mod24(hrs_r);
            if (Dayadv) day_r <= inc_mod7(day_r);
        end else if (Alarmset) begin
            sec_r <= sec_r;
        end else begin
            sec_r <= inc_mod60(sec_r);
            if (sec_r == 6'd59) begin
                min_r <= inc_mod60(min_r);
                if (min_r == 6'd59) begin
                    hrs_r <= inc_mod24(hrs_r);
                    if (hrs_r == 5'd23) begin
                        day_r <= inc_mod7(day_r);
                    end
                end
            end
        end
    end

    // Alarm set values: only the selected alarm is edited, minutes and hours independently.
    always_ff @(posedge Pulse) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (Reset) begin
                amin_r[i] <= 6'd0;
                ahrs_r[i] <= 5'd0;
            end else if (aset_s && sel_hit_s[i]) begin
                if (Minadv) amin_r[i] <= inc_mod60(amin_r[i]);
                if (Hrsadv) ahrs_r[i] <= inc_mod24(ahrs_r[i]);
            end
        end
    end

    // Per-alarm ring/snooze FSM with shared timer and registered Active flag.
    always_ff @(posedge Pulse) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (Reset || !Alarmon[i]) begin
                state_r[i]  <= ST_IDLE;
                timer_r[i]  <= 12'd0;
                active_r[i] <= 1'b0;
            end else begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (run_s && (sec_r == 6'd0) && (min_r == amin_r[i]) &&
                            (hrs_r == ahrs_r[i])) begin
                            state_r[i]  <= ST_RINGING;
                            timer_r[i]  <= 12'd0;
                            active_r[i] <= 1'b1;
                        end
                    end
                    ST_RINGING: begin
                        if (Snooze) begin
                            state_r[i]  <= ST_SNOOZED;
                            timer_r[i]  <= SNOOZE_CYC;
                            active_r[i] <= 1'b0;
                        end else if (timer_r[i] == RING_LAST) begin
                            state_r[i]  <= ST_IDLE;
                            timer_r[i]  <= 12'd0;
                            active_r[i] <= 1'b0;
                        end else begin
                            timer_r[i]  <= timer_r[i] + 12'd1;
                        end
                    end
                    ST_SNOOZED: begin
                        if (timer_r[i] == 12'd1) begin
                            state_r[i]  <= ST_RINGING;
                            timer_r[i]  <= 12'd0;
                            active_r[i] <= 1'b1;
                        end else begin
                            timer_r[i]  <= timer_r[i] - 12'd1;
                        end
                    end
                    default: begin
                        state_r[i]  <= ST_IDLE;
                        timer_r[i]  <= 12'd0;
                        active_r[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Display source: selected alarm during alarm set (00:00 if out of range), else time of day.
    always_comb begin
        disp_min_s   = 6'd0;
        disp_hrs24_s = 5'd0;
        if (aset_s) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                disp_min_s   = disp_min_s   | (sel_hit_s[i] ? amin_r[i] : 6'd0);
                disp_hrs24_s = disp_hrs24_s | (sel_hit_s[i] ? ahrs_r[i] : 5'd0);
            end
        end else begin
            disp_min_s   = min_r;
            disp_hrs24_s = hrs_r;
        end
    end

    // 12-hour presentation mapping; stored state is always 24-hour.
    always_comb begin
        disp_hrs_s = disp_hrs24_s;
        if (!Mode12) begin
            disp_hrs_s = disp_hrs24_s;
        end else if (disp_hrs24_s == 5'd0) begin
            disp_hrs_s = 5'd12;
        end else if (disp_hrs24_s > 5'd12) begin
            disp_hrs_s = disp_hrs24_s - 5'd12;
        end else begin
            disp_hrs_s = disp_hrs24_s;
        end
    end

    assign Sec     = {1'b0, sec_r};
    assign DispMin = {1'b0, disp_min_s};
    assign DispHrs = {2'b00, disp_hrs_s};
    assign Day     = day_r;
    assign PM      = (disp_hrs24_s >= 5'd12);
    assign Active  = active_r;
    assign Buzz    = |active_r;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi: directed scenarios plus a randomized phase,
// all checked against a seconds-of-week / remaining-cycles reference model.
module tb_alarm_clock_multi;

    localparam int N  = 3;
    localparam int SN = 300;
    localparam int RM = 600;

    logic       Pulse = 1'b0;
    logic       Reset = 1'b1;
    logic       Timeset = 1'b0, Alarmset = 1'b0;
    logic       Minadv = 1'b0, Hrsadv = 1'b0, Dayadv = 1'b0;
    logic [1:0] Alarmsel = 2'd0;
    logic [2:0] Alarmon = 3'b000;
    logic       Snooze = 1'b0, Mode12 = 1'b0;
    logic [6:0] Sec, DispMin, DispHrs;
    logic [2:0] Day;
    logic       PM;
    logic [2:0] Active;
    logic       Buzz;

    int tests = 0;
    int fails = 0;

    int m_tod;
    int m_amin [N];
    int m_ahrs [N];
    int m_ring [N];
    int m_snz  [N];

    alarm_clock_multi #(.NUM_ALARMS(N), .SNOOZE_MIN(5), .RING_MAX_SEC(RM)) dut (
        .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset), .Alarmset(Alarmset),
        .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv), .Alarmsel(Alarmsel),
        .Alarmon(Alarmon), .Snooze(Snooze), .Mode12(Mode12), .Sec(Sec),
        .DispMin(DispMin), .DispHrs(DispHrs), .Day(Day), .PM(PM),
        .Active(Active), .Buzz(Buzz)
    );

    always #5 Pulse = ~Pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int h12(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_edge();
        int s, mi, h, d;
        s  = m_tod % 60;
        mi = (m_tod / 60) % 60;
        h  = (m_tod / 3600) % 24;
        d  = m_tod / 86400;
        if (Reset) begin
            m_tod = 0;
            for (int i = 0; i < N; i++) begin
                m_amin[i] = 0; m_ahrs[i] = 0; m_ring[i] = 0; m_snz[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!Alarmon[i]) begin
                    m_ring[i] = 0; m_snz[i] = 0;
                end else if (m_ring[i] > 0) begin
                    if (Snooze) begin m_ring[i] = 0; m_snz[i] = SN; end
                    else m_ring[i] = m_ring[i] - 1;
                end else if (m_snz[i] > 0) begin
                    m_snz[i] = m_snz[i] - 1;
                    if (m_snz[i] == 0) m_ring[i] = RM;
                end else if (!Timeset && !Alarmset && s == 0 &&
                             mi == m_amin[i] && h == m_ahrs[i]) begin
                    m_ring[i] = RM;
                end
            end
            if (Timeset) begin
                if (Minadv) mi = (mi + 1) % 60;
                if (Hrsadv) h = (h + 1) % 24;
                if (Dayadv) d = (d + 1) % 7;
                m_tod = d * 86400 + h * 3600 + mi * 60 + s;
            end else if (Alarmset) begin
                if (int'(Alarmsel) < N) begin
                    if (Minadv) m_amin[Alarmsel] = (m_amin[Alarmsel] + 1) % 60;
                    if (Hrsadv) m_ahrs[Alarmsel] = (m_ahrs[Alarmsel] + 1) % 24;
                end
            end else begin
                m_tod = (m_tod + 1) % 604800;
            end
        end
    endtask

    task automatic check_all();
        int dm, dh;
        logic [2:0] act;
        if (Alarmset && !Timeset) begin
            if (int'(Alarmsel) < N) begin
                dm = m_amin[Alarmsel]; dh = m_ahrs[Alarmsel];
            end else begin
                dm = 0; dh = 0;
            end
        end else begin
            dm = (m_tod / 60) % 60; dh = (m_tod / 3600) % 24;
        end
        for (int i = 0; i < N; i++) act[i] = (m_ring[i] > 0);
        chk("sec", 32'(Sec), 32'(m_tod % 60));
        chk("day", 32'(Day), 32'(m_tod / 86400));
        chk("dispmin", 32'(DispMin), 32'(dm));
        chk("disphrs", 32'(DispHrs), 32'(Mode12 ? h12(dh) : dh));
        chk("pm", 32'(PM), 32'(dh >= 12));
        chk("active", 32'(Active), 32'(act));
        chk("buzz", 32'(Buzz), 32'(act != 3'b000));
    endtask

    task automatic step(input bit do_chk);
        @(posedge Pulse);
        model_edge();
        #1;
        if (do_chk) check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1);
    endtask

    initial begin
        int lowcnt, ringcnt;
        m_tod = 0;
        for (int i = 0; i < N; i++) begin
            m_amin[i] = 7; m_ahrs[i] = 7; m_ring[i] = 0; m_snz[i] = 0;
        end

        // Reset state
        Reset = 1'b1;
        run(2);
        Reset = 1'b0;
        chk("rst_sec", 32'(Sec), 32'd0);
        chk("rst_hrs24", 32'(DispHrs), 32'd0);
        Mode12 = 1'b1;
        #1;
        chk("rst_hrs12", 32'(DispHrs), 32'd12);
        chk("rst_pm", 32'(PM), 32'd0);
        Mode12 = 1'b0;

        // One full day of free running
        for (int k = 0; k < 86400; k++) step((k % 997) == 0);
        check_all();
        chk("day_sec", 32'(Sec), 32'd0);
        chk("day_min", 32'(DispMin), 32'd0);
        chk("day_hrs", 32'(DispHrs), 32'd0);
        chk("day_day", 32'(Day), 32'd1);

        // Time to 07:29:00, alarm 1 to 07:30
        Timeset = 1'b1; Hrsadv = 1'b1; Minadv = 1'b1;
        run(7);
        Hrsadv = 1'b0;
        run(22);
        Timeset = 1'b0; Alarmset = 1'b1; Alarmsel = 2'd1; Hrsadv = 1'b1;
        run(7);
        Hrsadv = 1'b0;
        run(23);
        Alarmset = 1'b0; Minadv = 1'b0; Alarmon = 3'b010;
        run(58);
        chk("set_sec", 32'(Sec), 32'd58);
        chk("set_min", 32'(DispMin), 32'd29);
        run(3);
        chk("ring_act", 32'(Active), 32'b010);
        chk("ring_buzz", 32'(Buzz), 32'd1);
        chk("ring_sec", 32'(Sec), 32'd1);
        chk("ring_min", 32'(DispMin), 32'd30);
        chk("ring_hrs", 32'(DispHrs), 32'd7);

        // Snooze for exactly 300 cycles, then ring until auto-off
        run(4);
        Snooze = 1'b1;
        step(1'b1);
        Snooze = 1'b0;
        lowcnt = (Buzz === 1'b0) ? 1 : 0;
        while (Buzz !== 1'b1 && lowcnt < 400) begin
            step(1'b1);
            if (Buzz !== 1'b1) lowcnt++;
        end
        chk("snooze_len", 32'(lowcnt), 32'd300);
        ringcnt = (Buzz === 1'b1) ? 1 : 0;
        while (Buzz === 1'b1 && ringcnt < 700) begin
            step(1'b1);
            if (Buzz === 1'b1) ringcnt++;
        end
        chk("ring_len", 32'(ringcnt), 32'd600);

        // Two alarms at 06:00
        Reset = 1'b1;
        step(1'b1);
        Reset = 1'b0;
        Alarmset = 1'b1; Alarmsel = 2'd0; Hrsadv = 1'b1;
        run(6);
        Alarmsel = 2'd1;
        run(6);
        Hrsadv = 1'b0; Alarmset = 1'b0;
        Timeset = 1'b1; Hrsadv = 1'b1; Minadv = 1'b1;
        run(5);
        Hrsadv = 1'b0;
        run(54);
        Timeset = 1'b0; Minadv = 1'b0; Alarmon = 3'b011;
        run(61);
        chk("both_act", 32'(Active), 32'b011);
        Alarmon = 3'b010;
        step(1'b1);
        chk("drop_act", 32'(Active), 32'b010);

        // 12-hour display at 12, 13 and 00 hours
        Mode12 = 1'b1; Timeset = 1'b1; Hrsadv = 1'b1;
        run(6);
        chk("h12_12", 32'(DispHrs), 32'd12);
        chk("pm_12", 32'(PM), 32'd1);
        step(1'b1);
        chk("h12_13", 32'(DispHrs), 32'd1);
        chk("pm_13", 32'(PM), 32'd1);
        run(11);
        chk("h12_00", 32'(DispHrs), 32'd12);
        chk("pm_00", 32'(PM), 32'd0);
        Hrsadv = 1'b0;

        // Timeset wins over Alarmset; out-of-range selector
        Alarmset = 1'b1; Minadv = 1'b1;
        step(1'b1);
        chk("ts_as_min", 32'(DispMin), 32'd1);
        Timeset = 1'b0; Mode12 = 1'b0; Alarmsel = 2'd3; Hrsadv = 1'b1;
        step(1'b1);
        chk("oor_min", 32'(DispMin), 32'd0);
        chk("oor_hrs", 32'(DispHrs), 32'd0);
        Minadv = 1'b0; Hrsadv = 1'b0; Alarmsel = 2'd1;
        #1;
        check_all();
        chk("oor_keep_hrs", 32'(DispHrs), 32'd6);

        // Reset while ringing
        Alarmset = 1'b0;
        chk("pre_rst_buzz", 32'(Buzz), 32'd1);
        Reset = 1'b1;
        step(1'b1);
        Reset = 1'b0;
        chk("mid_rst_act", 32'(Active), 32'd0);

        // Randomized phase; alarms at 00:00 re-trigger after every reset
        Alarmon = 3'b111;
        for (int k = 0; k < 2000; k++) begin
            Reset    = ($urandom_range(299) == 0);
            Timeset  = ($urandom_range(7) == 0);
            Alarmset = ($urandom_range(5) == 0);
            Minadv   = 1'($urandom);
            Hrsadv   = 1'($urandom);
            Dayadv   = 1'($urandom);
            Alarmsel = 2'($urandom);
            Snooze   = ($urandom_range(19) == 0);
            Mode12   = 1'($urandom);
            if ($urandom_range(49) == 0) Alarmon = 3'($urandom);
            step(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
